pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program-counter register and sequences next-PC selection for the fetch stage: sequential increment, taken-branch redirect, jump redirect, stall hold and post-redirect flush.
- Contains the branch-target arithmetic of the PC branch adder.
- Sits between the instruction-memory fetch port and the EX/ID redirect sources.
- PC values are word addresses confined to the 16-bit instruction space.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; must satisfy RESET_PC & ~PC_MASK == 0.
- PC_MASK, 32'h0000FFFF, address-space mask applied to every PC update.
- FLUSH_CYCLES, 1, bubble cycles after a redirect; legal range 1-3.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  pipeline hazard stall; holds PC.
- fetch_ready  input  1  instruction memory accepts pc this cycle.
- branch_taken  input  1  EX-stage branch resolved taken.
- branch_pc  input  32  PC of the branching instruction.
- branch_offset  input  32  byte offset from the branch immediate.
- jump_valid  input  1  ID-stage unconditional jump request.
- jump_target  input  32  jump destination, word address.
- pc  output  32  current fetch address.
- fetch_valid  output  1  pc is a valid fetch request.
- flush  output  1  kill the instructions in IF/ID.

Behaviour:
- Reset: on any cycle where reset=1, the next state is pc=RESET_PC, fetch_valid=0, flush=0 and FSM=BOOT. Reset overrides all other inputs, including a redirect in flight.
- FSM states: BOOT, RUN, FLUSH.
  - BOOT: lasts 1 cycle, fetch_valid=0, then goes to RUN.
  - RUN: fetch_valid=1.
  - FLUSH: fetch_valid=0, flush=1, stays for FLUSH_CYCLES cycles (down-counter), then goes to RUN.
- Branch target: (branch_pc + (branch_offset >> 2)) & PC_MASK. Use a logical shift; the mask removes high bits produced by negative offsets.
- Jump target: jump_target & PC_MASK.
- Sequential next PC: (pc + 1) & PC_MASK. 0x0000FFFF wraps to 0x00000000.
- Next-PC priority, highest first: reset > branch_taken > jump_valid > stall > handshake advance > hold.
- Redirect: branch_taken or jump_valid sampled in RUN or FLUSH at cycle N.
  - At N+1: pc=target, FSM=FLUSH, flush=1, counter reloaded to FLUSH_CYCLES.
  - At N+1+FLUSH_CYCLES: fetch_valid=1 presenting the target.
  - A redirect during FLUSH restarts the flush with the new target.
  - A redirect overrides stall.
  - Redirect inputs are ignored in BOOT.
- Simultaneous branch_taken and jump_valid: the branch wins (older instruction); the jump is dropped.
- Advance: in RUN, pc advances only when fetch_valid & fetch_ready & ~stall. Otherwise pc holds and fetch_valid stays 1; a request is never withdrawn while unaccepted.
- stall or fetch_ready=0 during FLUSH has no effect on the flush count.
- All outputs are registered. No combinational path exists from inputs to outputs.

Optional Feature:
- Macro: PC_SEQ_PERF_COUNTERS_EN.
- With the macro: adds outputs redirect_count[31:0] and stall_count[31:0].
  - redirect_count increments on every accepted redirect.
  - stall_count increments on every RUN cycle with fetch_valid=1 where no advance occurred.
  - Both counters reset to 0 on reset and saturate at 0xFFFFFFFF.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset sequence: reset=1 for 2 cycles, then 0, fetch_ready=1.
  - Required: pc=0x0 and fetch_valid=0 for one BOOT cycle.
  - Then fetch_valid=1 and pc increments 0x0,0x1,0x2 per cycle.
- Forward branch: branch_pc=0x10, branch_offset=0x20, branch_taken at cycle N.
  - Required: pc=0x18 at N+1, flush=1 for 1 cycle.
  - fetch_valid=1 with pc=0x18 at N+2.
- Backward branch: branch_pc=0x10, branch_offset=0xFFFFFFF0.
  - Required: pc=0x0000000C.
  - Upper 16 bits of pc remain zero.
- Stall and handshake:
  - stall=1 for 3 cycles at pc=0x5: pc holds 0x5 with fetch_valid=1; resumes at 0x6.
  - fetch_ready=0 gives the same hold.
- Wrap and collision:
  - pc=0xFFFF advances to 0x0000.
  - Same-cycle branch_taken (target 0x40) and jump_valid (target 0x80): pc=0x40.
- Reset mid-flush: FLUSH_CYCLES=3, assert reset during the 2nd flush cycle.
  - Required: next cycle pc=RESET_PC, flush=0, FSM=BOOT.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential advance, branch/jump redirect,
// stall hold and post-redirect flush. Define PC_SEQ_PERF_COUNTERS_EN to add perf counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] PC_MASK      = 32'h0000_FFFF,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
`ifdef PC_SEQ_PERF_COUNTERS_EN
  output logic [31:0] redirect_count,
  output logic [31:0] stall_count,
`endif
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        fetch_valid_reg, fetch_valid_next;
  logic        flush_reg, flush_next;
  logic [1:0]  flush_cnt_reg, flush_cnt_next;

  logic [31:0] branch_target;
  logic [31:0] jump_target_masked;
  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        handshake;
  logic        advance;

  // Offset is a byte offset; the logical shift converts it to words and the
  // mask discards the high bits a negative offset leaves behind.
  always_comb begin
    branch_target      = (branch_pc + (branch_offset >> 2)) & PC_MASK;
    jump_target_masked = jump_target & PC_MASK;
    seq_pc             = (pc_reg + 32'd1) & PC_MASK;
    redirect           = branch_taken | jump_valid;
    redirect_pc        = branch_taken ? branch_target : jump_target_masked;
    handshake          = fetch_valid_reg & fetch_ready & ~stall;
    advance            = (state_reg == ST_RUN) & handshake;
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          state_next     = ST_FLUSH;
          pc_next        = redirect_pc;
          flush_cnt_next = FLUSH_LOAD;
        end else if (advance) begin
          pc_next = seq_pc;
        end
      end
      ST_FLUSH: begin
        // A new redirect restarts the bubble count; stall/ready are ignored here.
        if (redirect) begin
          pc_next        = redirect_pc;
          flush_cnt_next = FLUSH_LOAD;
        end else if (flush_cnt_reg <= 2'd1) begin
          state_next     = ST_RUN;
          flush_cnt_next = 2'd0;
        end else begin
          flush_cnt_next = flush_cnt_reg - 2'd1;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
    fetch_valid_next = (state_next == ST_RUN);
    flush_next       = (state_next == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_PC;
      fetch_valid_reg <= 1'b0;
      flush_reg       <= 1'b0;
      flush_cnt_reg   <= 2'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fetch_valid_reg <= fetch_valid_next;
      flush_reg       <= flush_next;
      flush_cnt_reg   <= flush_cnt_next;
    end
  end

  assign pc          = pc_reg;
  assign fetch_valid = fetch_valid_reg;
  assign flush       = flush_reg;

`ifdef PC_SEQ_PERF_COUNTERS_EN
  logic [31:0] redirect_count_reg;
  logic [31:0] stall_count_reg;
  logic        redirect_event;
  logic        stall_event;

  always_comb begin
    redirect_event = redirect & (state_reg != ST_BOOT);
    stall_event    = (state_reg == ST_RUN) & fetch_valid_reg & ~handshake;
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_count_reg <= 32'd0;
      stall_count_reg    <= 32'd0;
    end else begin
      if (redirect_event && (redirect_count_reg != 32'hFFFF_FFFF))
        redirect_count_reg <= redirect_count_reg + 32'd1;
      if (stall_event && (stall_count_reg != 32'hFFFF_FFFF))
        stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign redirect_count = redirect_count_reg;
  assign stall_count    = stall_count_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan cases plus random stimulus,
// checked every cycle against a behavioural model for FLUSH_CYCLES=1 and 3.
module tb_pc_sequencer;

  localparam logic [31:0] MASK   = 32'h0000_FFFF;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, branch_taken, jump_valid;
  logic [31:0] branch_pc, branch_offset, jump_target;
  logic [31:0] pc1, pc3;
  logic        fv1, fv3, fl1, fl3;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC), .PC_MASK(MASK), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .pc(pc1), .fetch_valid(fv1), .flush(fl1)
  );

  pc_sequencer #(.RESET_PC(RST_PC), .PC_MASK(MASK), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .pc(pc3), .fetch_valid(fv3), .flush(fl3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Model: what the outputs must be after each edge, from the rules alone.
  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        boot;
    logic [3:0]  bubbles;
  } mstate_t;

  mstate_t m1 = '0;
  mstate_t m3 = '0;
  logic    m_valid = 1'b0;

  function automatic mstate_t model_step(input mstate_t s, input int fc);
    mstate_t n = s;
    if (reset) begin
      n.pc = RST_PC; n.fv = 1'b0; n.fl = 1'b0; n.boot = 1'b1; n.bubbles = 4'd0;
    end else if (s.boot) begin
      n.boot = 1'b0; n.fv = 1'b1; n.fl = 1'b0;
    end else if (branch_taken || jump_valid) begin
      n.pc = branch_taken ? ((branch_pc + branch_offset / 4) & MASK) : (jump_target & MASK);
      n.fv = 1'b0; n.fl = 1'b1; n.bubbles = 4'(fc);
    end else if (s.bubbles != 0) begin
      n.bubbles = s.bubbles - 4'd1;
      if (n.bubbles == 0) begin
        n.fv = 1'b1; n.fl = 1'b0;
      end
    end else if (fetch_ready && !stall) begin
      n.pc = (s.pc + 32'd1) & MASK;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= model_step(m1, 1);
    m3 <= model_step(m3, 3);
    if (reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pc_f1", pc1, m1.pc);
      check("model_fv_f1", {31'd0, fv1}, {31'd0, m1.fv});
      check("model_fl_f1", {31'd0, fl1}, {31'd0, m1.fl});
      check("model_pc_f3", pc3, m3.pc);
      check("model_fv_f3", {31'd0, fv3}, {31'd0, m3.fv});
      check("model_fl_f3", {31'd0, fl3}, {31'd0, m3.fl});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
    branch_taken = 1'b0; jump_valid = 1'b0;
    branch_pc = 32'd0; branch_offset = 32'd0; jump_target = 32'd0;

    // Reset and boot
    tick();
    check("rst_pc", pc1, 32'h0);
    check("rst_fv", {31'd0, fv1}, 32'd0);
    check("rst_fl", {31'd0, fl1}, 32'd0);
    tick();
    reset = 1'b0;
    check("boot_fv", {31'd0, fv1}, 32'd0);
    check("boot_pc", pc1, 32'h0);
    tick();
    check("run_fv", {31'd0, fv1}, 32'd1);
    check("run_pc0", pc1, 32'h0);
    tick();
    check("run_pc1", pc1, 32'h1);
    tick();
    check("run_pc2", pc1, 32'h2);

    // Forward branch
    branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = 32'h20;
    tick();
    check("fwd_pc", pc1, 32'h18);
    check("fwd_flush", {31'd0, fl1}, 32'd1);
    check("fwd_fv", {31'd0, fv1}, 32'd0);
    check("fwd_model_pc", m1.pc, 32'h18);
    branch_taken = 1'b0;
    tick();
    check("fwd_fv_after", {31'd0, fv1}, 32'd1);
    check("fwd_pc_after", pc1, 32'h18);
    check("fwd_flush_after", {31'd0, fl1}, 32'd0);

    // Backward branch
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF0;
    tick();
    check("bwd_pc", pc1, 32'h0000_000C);
    check("bwd_model_pc", m1.pc, 32'h0000_000C);
    branch_taken = 1'b0;
    tick();
    check("bwd_fv", {31'd0, fv1}, 32'd1);

    // Stall and handshake hold at pc=5 (jump target high bits must be masked)
    jump_valid = 1'b1; jump_target = 32'hABCD_0005;
    tick();
    check("jmp_pc", pc1, 32'h5);
    jump_valid = 1'b0;
    tick();
    check("jmp_fv", {31'd0, fv1}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc1, 32'h5);
      check("stall_fv", {31'd0, fv1}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall_resume", pc1, 32'h6);
    fetch_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("notready_pc", pc1, 32'h6);
      check("notready_fv", {31'd0, fv1}, 32'd1);
    end
    fetch_ready = 1'b1;
    tick();
    check("ready_resume", pc1, 32'h7);

    // Wrap
    jump_valid = 1'b1; jump_target = 32'h0000_FFFF;
    tick();
    jump_valid = 1'b0;
    tick();
    check("wrap_top", pc1, 32'hFFFF);
    tick();
    check("wrap_zero", pc1, 32'h0);

    // Branch/jump collision: branch wins
    branch_taken = 1'b1; branch_pc = 32'h40; branch_offset = 32'h0;
    jump_valid = 1'b1; jump_target = 32'h80;
    tick();
    check("collide_pc", pc1, 32'h40);
    check("collide_pc_f3", pc3, 32'h40);
    branch_taken = 1'b0; jump_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset in the second flush cycle of the 3-cycle instance
    branch_taken = 1'b1; branch_pc = 32'h100;
    tick();
    check("mf_pc", pc3, 32'h100);
    check("mf_flush1", {31'd0, fl3}, 32'd1);
    branch_taken = 1'b0;
    tick();
    check("mf_flush2", {31'd0, fl3}, 32'd1);
    reset = 1'b1;
    tick();
    check("mf_rst_pc", pc3, RST_PC);
    check("mf_rst_flush", {31'd0, fl3}, 32'd0);
    check("mf_rst_fv", {31'd0, fv3}, 32'd0);
    reset = 1'b0;
    tick();
    check("mf_run_fv", {31'd0, fv3}, 32'd1);
    check("mf_run_pc", pc3, RST_PC);

    // Random stimulus, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(99) == 0);
      branch_taken = ($urandom_range(11) == 0);
      jump_valid   = ($urandom_range(11) == 0);
      stall        = ($urandom_range(3) == 0);
      fetch_ready  = ($urandom_range(3) != 0);
      branch_pc    = $urandom;
      branch_offset = ($urandom_range(1) == 0) ? $urandom : (32'($urandom_range(64)) - 32'd32);
      jump_target  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFE : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
